tiled_mult_pipe: RTL and testbench

//  Parametrised, pipelined A_W x B_W tiled multiplier; successor to the fixed 66x66 tile multiplier.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_tile_row.sv | 47 ++++
 rtl/tiled_mult_pipe.sv | 117 +++++++++++
 tb/tb_tiled_mult_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared sizing helpers for the tiled multiplier: tile counts, shift offsets
// and the default DSP-friendly tile geometry.
package mult_pkg;

  localparam int DEF_TA_W = 22;
  localparam int DEF_TB_W = 17;

  function automatic int ceil_div(input int w, input int t);
    return (w + t - 1) / t;
  endfunction

  // Bit offset of tile idx when tiles are tile_w wide.
  function automatic int tile_shift(input int idx, input int tile_w);
    return idx * tile_w;
  endfunction

endpackage

// File: rtl/mult_tile_row.sv
// One a-tile against all NB b-tiles: registered tile products (S1) and their
// shifted row sum (S2). Both stages advance only when en_i is high.
module mult_tile_row
  import mult_pkg::*;
#(
  parameter int TA_W = DEF_TA_W,
  parameter int TB_W = DEF_TB_W,
  parameter int NB   = 4
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic [TA_W-1:0]          a_tile_i,
  input  logic [NB*TB_W-1:0]       b_i,
  output logic [TA_W+NB*TB_W-1:0]  row_sum_o
);

  localparam int PP_W  = TA_W + TB_W;
  localparam int ROW_W = TA_W + NB * TB_W;

  logic [PP_W-1:0]  pp_q [NB];
  logic [ROW_W-1:0] row_d;
  logic [ROW_W-1:0] row_q;

  // NOTE: pure datapath registers carry no reset; their contents only matter
  // when the matching valid bit (which is reset) says so.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int j = 0; j < NB; j++) begin
        pp_q[j] <= PP_W'(a_tile_i) * PP_W'(b_i[j*TB_W +: TB_W]);
      end
    end
  end

  always_comb begin
    row_d = '0;
    for (int j = 0; j < NB; j++) begin
      row_d = row_d + (ROW_W'(pp_q[j]) << tile_shift(j, TB_W));
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) row_q <= row_d;
  end

  assign row_sum_o = row_q;

endmodule

// File: rtl/tiled_mult_pipe.sv
// Three-stage tiled multiplier with valid/ready flow control, per-beat
// signed/unsigned mode and a sideband tag carried alongside the product.
module tiled_mult_pipe
  import mult_pkg::*;
#(
  parameter int A_W   = 66,
  parameter int B_W   = 66,
  parameter int TA_W  = DEF_TA_W,
  parameter int TB_W  = DEF_TB_W,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NA    = ceil_div(A_W, TA_W);
  localparam int NB    = ceil_div(B_W, TB_W);
  localparam int AP_W  = NA * TA_W;
  localparam int BP_W  = NB * TB_W;
  localparam int ROW_W = TA_W + BP_W;
  localparam int SUM_W = AP_W + BP_W;
  localparam int P_W   = A_W + B_W;

  logic             advance;
  logic [A_W-1:0]   mag_a;
  logic [B_W-1:0]   mag_b;
  logic [AP_W-1:0]  a_pad;
  logic [BP_W-1:0]  b_pad;
  logic             neg_d;
  logic [ROW_W-1:0] row_sum [NA];
  logic [SUM_W-1:0] sum_acc;
  logic [P_W-1:0]   prod_d;

  logic             v1_q, v2_q, out_valid_q;
  logic             neg1_q, neg2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, out_tag_q;
  logic [P_W-1:0]   out_p_q;

  // The whole pipe moves as one; a held output freezes every stage behind it.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  // Signed minimum negates onto itself, which read unsigned is its magnitude.
  always_comb begin
    mag_a = in_a;
    mag_b = in_b;
    if (in_signed && in_a[A_W-1]) mag_a = ~in_a + A_W'(1);
    if (in_signed && in_b[B_W-1]) mag_b = ~in_b + B_W'(1);
    neg_d = in_signed & (in_a[A_W-1] ^ in_b[B_W-1]);
    a_pad = AP_W'(mag_a);
    b_pad = BP_W'(mag_b);
  end

  for (genvar i = 0; i < NA; i++) begin : g_row
    mult_tile_row #(
      .TA_W (TA_W),
      .TB_W (TB_W),
      .NB   (NB)
    ) u_row (
      .clk       (clk),
      .en_i      (advance),
      .a_tile_i  (a_pad[i*TA_W +: TA_W]),
      .b_i       (b_pad),
      .row_sum_o (row_sum[i])
    );
  end

  always_comb begin
    sum_acc = '0;
    for (int i = 0; i < NA; i++) begin
      sum_acc = sum_acc + (SUM_W'(row_sum[i]) << tile_shift(i, TA_W));
    end
    prod_d = P_W'(sum_acc);
    if (neg2_q) prod_d = ~prod_d + P_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      out_tag_q   <= '0;
      out_p_q     <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      neg1_q      <= neg_d;
      tag1_q      <= in_tag;
      v2_q        <= v1_q;
      neg2_q      <= neg1_q;
      tag2_q      <= tag1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_p_q   <= prod_d;
        out_tag_q <= tag2_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_tiled_mult_pipe.sv
// Scoreboard bench: default 66x66 instance plus a 40x33 partial-tile instance.
module tb_tiled_mult_pipe;

  logic         clk;
  logic         rst_n;

  logic         in_valid, in_ready, in_signed;
  logic [65:0]  in_a, in_b;
  logic [3:0]   in_tag, out_tag;
  logic         out_valid, out_ready;
  logic [131:0] out_p;

  logic         in_valid2, in_ready2, in_signed2;
  logic [39:0]  in_a2;
  logic [32:0]  in_b2;
  logic [3:0]   in_tag2, out_tag2;
  logic         out_valid2, out_ready2;
  logic [72:0]  out_p2;

  typedef struct packed {
    logic [131:0] p;
    logic [3:0]   tag;
  } exp_t;

  typedef struct packed {
    logic [72:0] p;
    logic [3:0]  tag;
  } exp2_t;

  exp_t  sb[$];
  exp2_t sb2[$];
  int    checks = 0;
  int    errors = 0;
  int    out_cnt = 0;
  int    out_cnt2 = 0;

  tiled_mult_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag)
  );

  tiled_mult_pipe #(.A_W(40), .B_W(33), .TA_W(16), .TB_W(17), .TAG_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_signed(in_signed2),
    .in_a(in_a2), .in_b(in_b2), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_p(out_p2), .out_tag(out_tag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend both operands to full product width and multiply
  // modulo 2^(A_W+B_W), which is exact for both modes.
  function automatic logic [131:0] ref66(input logic s, input logic [65:0] a, input logic [65:0] b);
    logic [131:0] ea, eb;
    ea = s ? {{66{a[65]}}, a} : {66'b0, a};
    eb = s ? {{66{b[65]}}, b} : {66'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [72:0] ref73(input logic s, input logic [39:0] a, input logic [32:0] b);
    logic [72:0] ea, eb;
    ea = s ? {{33{a[39]}}, a} : {33'b0, a};
    eb = s ? {{40{b[32]}}, b} : {40'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [65:0] rand66();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[65:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        out_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got p=%h tag=%0d, required no output", out_p, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_p !== e.p || out_tag !== e.tag) begin
            errors++;
            $display("FAIL product: got p=%h tag=%0d, required p=%h tag=%0d", out_p, out_tag, e.p, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.p = ref66(in_signed, in_a, in_b);
        e.tag = in_tag;
        sb.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp2_t e;
    if (rst_n) begin
      if (out_valid2 && out_ready2) begin
        checks++;
        out_cnt2++;
        if (sb2.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out2: got p=%h tag=%0d, required no output", out_p2, out_tag2);
        end else begin
          e = sb2.pop_front();
          if (out_p2 !== e.p || out_tag2 !== e.tag) begin
            errors++;
            $display("FAIL product2: got p=%h tag=%0d, required p=%h tag=%0d", out_p2, out_tag2, e.p, e.tag);
          end
        end
      end
      if (in_valid2 && in_ready2) begin
        e.p = ref73(in_signed2, in_a2, in_b2);
        e.tag = in_tag2;
        sb2.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b p=%h tag=%0d rdy=%b, required v=0 p=0 tag=0 rdy=1",
               out_valid, out_p, out_tag, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max();
    logic [131:0] expv;
    expv = 132'd0 - (132'd1 << 67) + 132'd1;
    tick();
    in_valid = 1'b1; in_signed = 1'b0; in_a = '1; in_b = '1; in_tag = 4'hA;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got out_valid=%b, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_p !== expv || out_tag !== 4'hA) begin
      errors++;
      $display("FAIL unsigned_max: got v=%b p=%h tag=%0d, required v=1 p=%h tag=10",
               out_valid, out_p, out_tag, expv);
    end
    tick();
  endtask

  task automatic test_signed_corners();
    logic [131:0] exp_m5, exp_big;
    exp_m5  = 132'd0 - 132'd5;
    exp_big = 132'd1 << 130;
    in_valid = 1'b1; in_signed = 1'b1; in_a = '1; in_b = 66'd5; in_tag = 4'd1;
    tick();
    in_a = 66'd1 << 65; in_b = 66'd1 << 65; in_tag = 4'd2;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_p !== exp_m5) begin
      errors++;
      $display("FAIL signed_m1x5: got v=%b p=%h, required v=1 p=%h", out_valid, out_p, exp_m5);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_p !== exp_big) begin
      errors++;
      $display("FAIL signed_min_sq: got v=%b p=%h, required v=1 p=%h", out_valid, out_p, exp_big);
    end
    tick();
  endtask

  task automatic test_stream();
    int cnt0;
    cnt0 = out_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_signed = 1'($urandom_range(1));
      in_a = rand66();
      in_b = rand66();
      in_tag = 4'(i);
      #1;
      if (in_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stream_ready: got in_ready=%b at beat %0d, required 1", in_ready, i);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (out_cnt - cnt0 != 100) begin
      errors++;
      $display("FAIL stream_throughput: got %0d products, required 100", out_cnt - cnt0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int           cnt0, idx;
    logic         took;
    logic [131:0] p_hold;
    logic [3:0]   tag_hold;
    cnt0 = out_cnt;
    idx = 0;
    p_hold = '0;
    tag_hold = '0;
    for (int c = 0; c < 80; c++) begin
      out_ready = !(c >= 8 && c < 18);
      if (idx < 30) begin
        in_valid = 1'b1;
        in_signed = 1'($urandom_range(1));
        in_a = rand66();
        in_b = rand66();
        in_tag = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 8) begin
        p_hold = out_p;
        tag_hold = out_tag;
      end
      if (c >= 9 && c < 18) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_p !== p_hold || out_tag !== tag_hold) begin
          errors++;
          $display("FAIL stall_hold: cyc %0d got rdy=%b v=%b p=%h tag=%0d, required rdy=0 v=1 p=%h tag=%0d",
                   c, in_ready, out_valid, out_p, out_tag, p_hold, tag_hold);
        end
      end
      took = in_valid && in_ready;
      tick();
      if (took) idx++;
    end
    checks++;
    if (out_cnt - cnt0 != 30 || sb.size() != 0) begin
      errors++;
      $display("FAIL backpressure_count: got %0d products, %0d pending, required 30 and 0",
               out_cnt - cnt0, sb.size());
    end
  endtask

  task automatic test_param_sweep();
    int          cnt0, n_acc;
    logic [63:0] t;
    logic        took;
    cnt0 = out_cnt2;
    n_acc = 0;
    for (int c = 0; c < 90; c++) begin
      t = {$urandom(), $urandom()};
      if (c == 0) begin
        in_valid2 = 1'b1; in_signed2 = 1'b1; in_a2 = 40'd1 << 39; in_b2 = 33'd1 << 32;
      end else if (c == 1) begin
        in_valid2 = 1'b1; in_signed2 = 1'b0; in_a2 = '1; in_b2 = '1;
      end else if (c == 2) begin
        in_valid2 = 1'b1; in_signed2 = 1'b1; in_a2 = 40'd1 << 39; in_b2 = '1;
      end else if (c < 60) begin
        in_valid2 = ($urandom_range(3) != 0);
        in_signed2 = 1'($urandom_range(1));
        in_a2 = t[39:0];
        in_b2 = {$urandom(), 1'b0} ^ {32'b0, t[40]};
      end else begin
        in_valid2 = 1'b0;
      end
      in_tag2 = 4'(c);
      out_ready2 = (c >= 60) || ($urandom_range(3) != 0);
      #1;
      took = in_valid2 && in_ready2;
      tick();
      if (took) n_acc++;
    end
    checks++;
    if (out_cnt2 - cnt0 != n_acc || sb2.size() != 0) begin
      errors++;
      $display("FAIL sweep_count: got %0d products, %0d pending, required %0d and 0",
               out_cnt2 - cnt0, sb2.size(), n_acc);
    end
  endtask

  task automatic test_reset_midflight();
    int cnt0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_signed = 1'b0; in_a = rand66(); in_b = rand66(); in_tag = 4'(i + 4);
      tick();
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    sb.delete();
    sb2.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b p=%h, required v=0 p=0", out_valid, out_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = out_cnt;
    tick();
    in_valid = 1'b1; in_signed = 1'b1; in_a = '1; in_b = 66'd3; in_tag = 4'd7;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale: got out_valid=%b after reset release, required 0", out_valid);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (out_cnt - cnt0 != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset_count: got %0d products, %0d pending, required 1 and 0",
               out_cnt - cnt0, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_signed2 = 1'b0; in_a2 = '0; in_b2 = '0; in_tag2 = '0; out_ready2 = 1'b1;
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_stream();
    test_backpressure();
    test_param_sweep();
    test_reset_midflight();
    checks++;
    if (sb.size() != 0 || sb2.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d pending, required 0/0", sb.size(), sb2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
